// File: rtl/pipo_load_sequencer.sv
// Initiator side of the PIPO start/done load handshake: takes DEPTH elements
// from a valid/ready stream and loads each into its own bank register.
module pipo_load_sequencer #(
    parameter int N       = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_start,
    input  logic             in_valid,
    input  logic [N-1:0]     in_data,
    output logic             in_ready,
    output logic [DEPTH-1:0] reg_start,
    output logic [N-1:0]     reg_d,
    input  logic [DEPTH-1:0] reg_done,
    output logic             busy,
    output logic             load_done,
    output logic             error
);

    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW   = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        GET,
        ACK
    } state_t;

    state_t           r_state;
    logic [IDXW-1:0]  r_idx;
    logic [TW-1:0]    r_timer;
    logic [DEPTH-1:0] r_regStart;
    logic [N-1:0]     r_regD;
    logic             r_busy;
    logic             r_loadDone;
    logic             r_error;

    state_t           w_nextState;
    logic [IDXW-1:0]  w_nextIdx;
    logic [TW-1:0]    w_nextTimer;
    logic [DEPTH-1:0] w_nextRegStart;
    logic [N-1:0]     w_nextRegD;
    logic             w_nextBusy;
    logic             w_nextLoadDone;
    logic             w_nextError;

    logic             w_ack;
    logic             w_last;
    logic             w_timeout;

    // Only the done bit of the register currently being loaded counts.
    assign w_ack     = reg_done[r_idx];
    assign w_last    = (r_idx == IDXW'(DEPTH - 1));
    assign w_timeout = (r_timer == TW'(TIMEOUT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_timer    <= '0;
            r_regStart <= '0;
            r_regD     <= '0;
            r_busy     <= 1'b0;
            r_loadDone <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_idx      <= w_nextIdx;
            r_timer    <= w_nextTimer;
            r_regStart <= w_nextRegStart;
            r_regD     <= w_nextRegD;
            r_busy     <= w_nextBusy;
            r_loadDone <= w_nextLoadDone;
            r_error    <= w_nextError;
        end
    end

    // Start strobe and load_done default low so each lasts a single cycle.
    always_comb begin
        w_nextState    = r_state;
        w_nextIdx      = r_idx;
        w_nextTimer    = r_timer;
        w_nextRegStart = '0;
        w_nextRegD     = r_regD;
        w_nextBusy     = r_busy;
        w_nextLoadDone = 1'b0;
        w_nextError    = r_error;

        case (r_state)
            IDLE: begin
                if (frame_start) begin
                    w_nextState = GET;
                    w_nextIdx   = '0;
                    w_nextError = 1'b0;
                    w_nextBusy  = 1'b1;
                end
            end
            GET: begin
                if (in_valid) begin
                    w_nextRegD     = in_data;
                    w_nextRegStart = DEPTH'(1) << r_idx;
                    w_nextTimer    = '0;
                    w_nextState    = ACK;
                end
            end
            ACK: begin
                w_nextTimer = r_timer + TW'(1);
                if (w_ack) begin
                    if (w_last) begin
                        w_nextState    = IDLE;
                        w_nextIdx      = '0;
                        w_nextBusy     = 1'b0;
                        w_nextLoadDone = 1'b1;
                    end else begin
                        w_nextState = GET;
                        w_nextIdx   = r_idx + IDXW'(1);
                    end
                end else if (w_timeout) begin
                    w_nextState = IDLE;
                    w_nextBusy  = 1'b0;
                    w_nextError = 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign in_ready  = (r_state == GET);
    assign reg_start = r_regStart;
    assign reg_d     = r_regD;
    assign busy      = r_busy;
    assign load_done = r_loadDone;
    assign error     = r_error;

endmodule

// File: tb/tb_pipo_load_sequencer.sv
// Bench for pipo_load_sequencer: table of frames driven against a delayed-done
// bank model, with a scoreboard checking every start strobe and its data.
module tb_pipo_load_sequencer;

    logic       clk;
    logic       reset;
    logic       frame_start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [3:0] reg_start;
    logic [7:0] reg_d;
    logic [3:0] reg_done;
    logic       busy;
    logic       load_done;
    logic       error;

    pipo_load_sequencer #(.N(8), .DEPTH(4), .TIMEOUT(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_start(frame_start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .reg_start  (reg_start),
        .reg_d      (reg_d),
        .reg_done   (reg_done),
        .busy       (busy),
        .load_done  (load_done),
        .error      (error)
    );

    typedef struct {
        logic [3:0][7:0] d;
        logic [3:0][3:0] gap;
        int              delay;
        int              spurAt;
        int              midStartAt;
        int              suppressIdx;
        int              resetAt;
        bit              expErr;
        int              expLat;
    } vec_t;

    typedef struct packed {
        logic [3:0] start;
        logic [7:0] data;
    } exp_t;

    exp_t sbQ[$];
    vec_t vecs[8];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ldSeen = 0;
    int ldCyc = 0;
    int errCyc = -1;
    bit errPrev = 1'b0;

    int         bankDelay;
    logic [3:0] suppress;
    logic [3:0] spurious;
    logic [3:0] bankQ;
    logic [3:0] bankPend;
    int         bankCnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank model: done for a register comes back bankDelay cycles after its start.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bankQ    <= '0;
            bankPend <= '0;
            bankCnt  <= 0;
        end else begin
            bankQ <= '0;
            if (reg_start != '0) begin
                if (bankDelay <= 1) begin
                    bankQ <= reg_start & ~suppress;
                end else begin
                    bankPend <= reg_start & ~suppress;
                    bankCnt  <= bankDelay - 1;
                end
            end else if (bankPend != '0) begin
                if (bankCnt <= 1) begin
                    bankQ    <= bankPend;
                    bankPend <= '0;
                end else begin
                    bankCnt <= bankCnt - 1;
                end
            end
        end
    end

    assign reg_done = bankQ | spurious;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic failNow(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    // Advance one cycle, then compare any start strobe against the scoreboard.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (reg_start != '0) begin
            if (sbQ.size() == 0) begin
                failNow("unexpectedStrobe");
            end else begin
                e = sbQ.pop_front();
                checkOutput("strobe", int'(reg_start), int'(e.start));
                checkOutput("strobeData", int'(reg_d), int'(e.data));
            end
        end
        if (load_done) begin
            ldSeen++;
            ldCyc = cyc;
        end
        if (error && !errPrev) errCyc = cyc;
        errPrev = error;
    endtask

    task automatic applyStimulus(input vec_t v);
        int firstHs = 0;
        int errRef = 0;
        int budget;
        exp_t e;
        bankDelay = v.delay;
        suppress  = (v.suppressIdx >= 0) ? (4'b0001 << v.suppressIdx) : 4'b0000;
        ldSeen = 0;
        errCyc = -1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        checkOutput("busyOnStart", int'(busy), 1);
        checkOutput("errClearOnStart", int'(error), 0);
        in_valid = (v.gap[0] == 0);
        in_data  = v.d[0];
        for (int i = 0; i < 4; i++) begin
            budget = 0;
            while (!in_ready && busy && budget < 100) begin
                tick();
                budget++;
            end
            spurious = '0;
            if (!busy) break;
            if (budget >= 100) begin
                failNow("waitReady");
                break;
            end
            if (v.gap[i] > 0) begin
                in_valid = 1'b0;
                repeat (int'(v.gap[i])) begin
                    tick();
                    checkOutput("gapReady", int'(in_ready), 1);
                    checkOutput("gapStart", int'(reg_start), 0);
                end
            end
            in_valid = 1'b1;
            in_data  = v.d[i];
            if (i == 0) firstHs = cyc + 1;
            if (i == v.suppressIdx) errRef = cyc + 1;
            e.start = 4'b0001 << i;
            e.data  = v.d[i];
            sbQ.push_back(e);
            if (i == v.midStartAt) frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            if (i == v.resetAt) begin
                #1 reset = 1'b1;
                #1;
                checkOutput("rstStrobe", int'(reg_start), 0);
                checkOutput("rstBusy", int'(busy), 0);
                checkOutput("rstReady", int'(in_ready), 0);
                in_valid = 1'b0;
                tick();
                reset = 1'b0;
                tick();
                checkOutput("idleAfterReset", int'(in_ready), 0);
                checkOutput("noLoadDoneAfterReset", ldSeen, 0);
                return;
            end
            if (i == v.spurAt) begin
                spurious = 4'b1000;
                tick();
                checkOutput("spuriousIgnored", int'(in_ready), 0);
            end
            if (i < 3 && v.gap[i+1] == 0) begin
                in_data = v.d[i+1];
            end else begin
                in_valid = 1'b0;
            end
        end
        budget = 0;
        while (busy && budget < 200) begin
            tick();
            budget++;
        end
        if (budget >= 200) failNow("waitIdle");
        in_valid = 1'b0;
        repeat (3) tick();
        checkOutput("loadDoneCount", ldSeen, v.expErr ? 0 : 1);
        checkOutput("errorFlag", int'(error), int'(v.expErr));
        checkOutput("busyEnd", int'(busy), 0);
        if (v.expErr) checkOutput("timeoutCycles", errCyc - errRef, v.expLat);
        else          checkOutput("latency", ldCyc - firstHs + 1, v.expLat);
        checkOutput("queueEmpty", sbQ.size(), 0);
    endtask

    initial begin
        reset = 1'b1;
        frame_start = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        spurious = '0;
        suppress = '0;
        bankDelay = 1;

        vecs[0] = '{d: {8'h44, 8'h33, 8'h22, 8'h11}, gap: '0, delay: 1, spurAt: -1,
                    midStartAt: -1, suppressIdx: -1, resetAt: -1, expErr: 1'b0, expLat: 12};
        vecs[1] = '{d: {8'h44, 8'h33, 8'h22, 8'h11}, gap: {4'd0, 4'd5, 4'd0, 4'd0}, delay: 1,
                    spurAt: -1, midStartAt: -1, suppressIdx: -1, resetAt: -1, expErr: 1'b0, expLat: 17};
        vecs[2] = '{d: {8'hF0, 8'h0F, 8'h55, 8'hAA}, gap: '0, delay: 4, spurAt: 1,
                    midStartAt: -1, suppressIdx: -1, resetAt: -1, expErr: 1'b0, expLat: 24};
        vecs[3] = '{d: {8'h04, 8'h03, 8'h02, 8'h01}, gap: '0, delay: 1, spurAt: -1,
                    midStartAt: 2, suppressIdx: -1, resetAt: -1, expErr: 1'b0, expLat: 12};
        vecs[4] = '{d: {8'h3C, 8'hC3, 8'hA5, 8'h5A}, gap: '0, delay: 1, spurAt: -1,
                    midStartAt: -1, suppressIdx: 1, resetAt: -1, expErr: 1'b1, expLat: 16};
        vecs[5] = vecs[0];
        vecs[6] = '{d: {8'h66, 8'h99, 8'h88, 8'h77}, gap: '0, delay: 1, spurAt: -1,
                    midStartAt: -1, suppressIdx: -1, resetAt: 2, expErr: 1'b0, expLat: 0};
        vecs[7] = vecs[0];

        @(negedge clk);
        checkOutput("resetReady", int'(in_ready), 0);
        checkOutput("resetStrobe", int'(reg_start), 0);
        checkOutput("resetData", int'(reg_d), 0);
        checkOutput("resetBusy", int'(busy), 0);
        checkOutput("resetLoadDone", int'(load_done), 0);
        checkOutput("resetError", int'(error), 0);
        reset = 1'b0;
        tick();

        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v]);
        end

        checkOutput("finalQueueEmpty", sbQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipo_load_sequencer.md
Name: pipo_load_sequencer

Overview:
- Initiator side of the PIPO start/done load handshake.
- Accepts a frame of DEPTH matrix elements over a valid/ready stream and loads each element into its own PIPO register in a bank.
- For each element it drives a one-cycle start strobe with the data, then waits for that register's done before moving to the next element.
- Sits between the input data source and the operand register banks feeding the matrix multiplier datapath.

Parameters:
- N, 8, element width in bits.
- DEPTH, 4, elements per frame, which is also the number of PIPO registers in the bank; minimum 1.
- TIMEOUT, 15, maximum cycles to wait for done after a start before aborting; minimum 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- frame_start  input  1  single-cycle request to begin loading a frame.
- in_valid  input  1  in_data holds a valid element.
- in_data  input  N  element value.
- in_ready  output  1  sequencer accepts an element this cycle.
- reg_start  output  DEPTH  one-hot start strobe; bit i goes to register i.
- reg_d  output  N  load data, common to all registers in the bank.
- reg_done  input  DEPTH  done pulses returned by the bank.
- busy  output  1  frame in progress.
- load_done  output  1  one-cycle pulse when all DEPTH elements have been acknowledged.
- error  output  1  sticky flag set on timeout; cleared by reset or by the next accepted frame_start.

Behaviour:
- Reset is asynchronous and active-high, and is fixed by this spec.
  - Reset values: state=IDLE, idx=0, timer=0, in_ready=0, reg_start=0, reg_d=0, busy=0, load_done=0, error=0.
  - Reset asserted mid-frame clears everything immediately, including any strobe in flight. No partial-frame completion is reported.
- All outputs are registered. in_ready is decoded from state (high only in GET).
- idx has width max(1, clog2(DEPTH)). timer counts from 0 to TIMEOUT.
- State IDLE:
  - busy=0.
  - frame_start=1 moves to GET with idx=0, error=0, busy=1.
- State GET:
  - in_ready=1.
  - On in_valid&&in_ready: reg_d<=in_data, reg_start<=(1<<idx), timer<=0, move to ACK.
  - in_valid low holds GET indefinitely; there is no timeout while waiting for data.
- State ACK:
  - reg_start is high for exactly one cycle (the first ACK cycle), then cleared.
  - reg_d holds its value until the next load.
  - timer increments every ACK cycle.
  - reg_done[idx]=1 is the acknowledge:
    - if idx==DEPTH-1: load_done pulses for one cycle on entry to IDLE, idx<=0, busy<=0, move to IDLE;
    - otherwise idx<=idx+1 and move to GET.
  - reg_done bits other than idx are ignored.
  - Acknowledge and timer==TIMEOUT in the same cycle: the acknowledge wins.
  - timer==TIMEOUT with no acknowledge: error<=1, busy<=0, move to IDLE, no load_done.
- Latency with a bank that returns done one cycle after sampling start:
  - handshake at edge k; reg_start high in cycle k+1; done high in cycle k+2; back in GET (or IDLE) at cycle k+3.
  - Each element therefore costs 3 cycles when in_valid is held high.
- frame_start while busy is ignored.
- in_data presented outside GET is not consumed.
- DEPTH=1: a single element per frame; load_done follows the first acknowledge.

Test Plan:
- DEPTH=4, bank model gives done 1 cycle after start, frame_start then elements 0x11,0x22,0x33,0x44 with in_valid held high -> reg_start sequence 0001,0010,0100,1000, each high for 1 cycle with matching reg_d; load_done pulses once, 12 cycles after the first handshake; busy falls the same cycle; error=0.
- Same frame with in_valid low for 5 cycles before element 2 -> in_ready stays high and reg_start stays 0 during the gap; loaded values unchanged; no error.
- Bank never returns done for element 1, TIMEOUT=15 -> error=1 after 16 ACK cycles; busy=0; load_done never pulses. A subsequent frame_start clears error and a full frame completes.
- reg_done[3] asserted while waiting on idx=1 -> ignored; sequencer stays in ACK until reg_done[1] arrives.
- reset asserted asynchronously in the reg_start cycle for element 2 -> reg_start, busy and in_ready go to 0 without waiting for a clock edge; after reset release, a new frame loads from idx 0.
- frame_start pulsed mid-frame -> no effect; the frame completes normally with exactly one load_done.
